input_debouncer: RTL
====================

Name: input_debouncer

Overview:
- Input conditioner for the Nexys4 board-level path: 4 slide switches and 1 push-button.
- Takes raw asynchronous pad signals, synchronizes them, and debounces each one independently.
- Outputs are glitch-free levels plus one-cycle event pulses. The combinational switch/button-to-LED logic consumes the clean levels in place of raw pads.

Parameters:
- N_SW, 4, number of switch channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a new level (10 ms at 100 MHz). Legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- swt_raw  input  N_SW  raw switch pads, asynchronous.
- btn_raw  input  1  raw push-button pad, asynchronous, active-high.
- swt_clean  output  N_SW  debounced switch levels.
- btn_clean  output  1  debounced button level.
- btn_press  output  1  one-cycle pulse on btn_clean 0→1.
- swt_change  output  1  one-cycle pulse when any swt_clean bit changes.
- btn_release  output  1  one-cycle pulse on btn_clean 1→0. Present only with BTN_RELEASE_EN.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low. All state is cleared immediately on rst_n low, independent of clk.
- Reset values: swt_clean=0, btn_clean=0, btn_press=0, swt_change=0, btn_release=0. Sync flops, counters and FSMs also go to 0 / STABLE.
- Channels: N_SW+1 identical channels (switches plus button), each fully independent.
- Synchronizer: 2-FF per channel (sync1→sync2). s denotes the sync2 output.
- Per-channel FSM, states STABLE and CHECK, counter cnt (CNT_W bits):
  - STABLE: cnt=0. If s != clean → CHECK, cnt=1.
  - CHECK, s != clean:
    - cnt < DEBOUNCE_CYCLES−1 → cnt++.
    - cnt == DEBOUNCE_CYCLES−1 → clean <= s, cnt=0, → STABLE.
  - CHECK, s == clean (bounce back): → STABLE, cnt=0, clean unchanged.
- Latency: raw level first sampled at edge 1 → clean changes at edge DEBOUNCE_CYCLES+2, provided the raw level holds. Any reversion of s before then restarts qualification from zero.
- Pulses are registered and asserted in the same cycle that clean changes, for exactly one cycle.
  - btn_press: btn_clean rises.
  - swt_change: any swt_clean bit changes. Simultaneous changes on several switches produce a single one-cycle pulse.
- Button and switches may change in the same cycle; each pulse is generated independently.
- A level held continuously during reset is treated as a change after reset release. Example: switch high during reset → swt_clean rises DEBOUNCE_CYCLES+2 edges after release, with a swt_change pulse.
- Reset asserted mid-qualification: cnt is discarded and no pulse is produced.
- cnt never exceeds DEBOUNCE_CYCLES−1, so there is no wrap-around.

Optional Feature:
- Macro: BTN_RELEASE_EN.
- Defined: port btn_release exists; one-cycle pulse in the cycle btn_clean falls 1→0; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset then idle: rst_n low 3 cycles, all raw=0 → all outputs 0 throughout; rst_n asserted between edges clears outputs without waiting for an edge.
- Clean button press: btn_raw 0→1 before edge 1, held → btn_clean=1 and btn_press=1 after edge 6; btn_press=0 after edge 7; no further pulses while held.
- Bounce rejection: btn_raw pattern 1,1,0,1,1,1,1,1 (one value per cycle) → btn_clean rises only after 4 consecutive 1s at s, i.e. 9 edges after the first sample; exactly one btn_press.
- Glitch shorter than window: swt_raw[2] high for 3 cycles then low → swt_clean stays 0x0; swt_change never asserts.
- Simultaneous switches: swt_raw 0x0→0xA in one cycle → swt_clean 0x0→0xA in a single cycle with one swt_change pulse; later 0xA→0x2 → one swt_change pulse.
- Mid-operation reset and release (BTN_RELEASE_EN defined): press qualified, then btn_raw→0 → btn_release one-cycle pulse 6 edges later. Separately, rst_n pulsed low at cnt=2 → no pulse; qualification restarts from zero after reset release.

Source files
------------

// File: rtl/input_debouncer_if.sv
// Pad-side and clean-side signals of the switch/button conditioner.
// The btn_release member exists only when BTN_RELEASE_EN is defined.
interface input_debouncer_if #(
  parameter int N_SW = 4
);
  logic [N_SW-1:0] swt_raw;
  logic            btn_raw;
  logic [N_SW-1:0] swt_clean;
  logic            btn_clean;
  logic            btn_press;
  logic            swt_change;
`ifdef BTN_RELEASE_EN
  logic            btn_release;
`endif

  modport master (
    output swt_raw, btn_raw,
    input
`ifdef BTN_RELEASE_EN
          btn_release,
`endif
          swt_clean, btn_clean, btn_press, swt_change
  );

  modport slave (
    input  swt_raw, btn_raw,
    output
`ifdef BTN_RELEASE_EN
           btn_release,
`endif
           swt_clean, btn_clean, btn_press, swt_change
  );
endinterface

// File: rtl/input_debouncer.sv
// Synchronizes and debounces N_SW switches plus one button; registered event pulses.
// Optional macro BTN_RELEASE_EN adds the btn_release pulse on btn_clean 1->0.
module input_debouncer_ch #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o,
  output logic clean_d_o
);
  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_CHECK  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync2_q != clean_q) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CHECK: begin
        // A bounce back to the accepted level throws away the partial count.
        if (sync2_q == clean_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          clean_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_o   = clean_q;
  assign clean_d_o = clean_d;
endmodule

module input_debouncer #(
  parameter  int N_SW            = 4,
  parameter  int DEBOUNCE_CYCLES = 1000000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input_debouncer_if.slave bus
);
  // Channel N_SW is the button; channels below it are the switches.
  logic [N_SW:0] raw, clean, clean_nxt;
  logic          press_q, change_q;

  assign raw = {bus.btn_raw, bus.swt_raw};

  input_debouncer_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch [N_SW:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    (raw),
    .clean_o  (clean),
    .clean_d_o(clean_nxt)
  );

  // Pulses are built from next-state levels so they line up with the clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      press_q  <= clean_nxt[N_SW] & ~clean[N_SW];
      change_q <= |(clean_nxt[N_SW-1:0] ^ clean[N_SW-1:0]);
    end
  end

`ifdef BTN_RELEASE_EN
  logic release_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) release_q <= 1'b0;
    else        release_q <= ~clean_nxt[N_SW] & clean[N_SW];
  end
  assign bus.btn_release = release_q;
`endif

  assign bus.swt_clean  = clean[N_SW-1:0];
  assign bus.btn_clean  = clean[N_SW];
  assign bus.btn_press  = press_q;
  assign bus.swt_change = change_q;
endmodule
